// File: rtl/noc_out_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_out_port_arbiter_if
//
// Bundles the four requester handshakes and the single downstream handshake of
// the router output-port arbiter.
//
//   in_valid  [NUM_IN]              requester i presents a packet
//   in_data   [NUM_IN*WIDTH_PACKET] requester i packet in [i*WIDTH_PACKET +: WIDTH_PACKET]
//   in_ready  [NUM_IN]              requester i's packet is accepted this cycle
//   out_valid                       output register holds a packet
//   out_data  [WIDTH_PACKET]        packet in the output register
//   out_src   [2]                   requester that supplied out_data
//   out_ready                       downstream accepts out_data this cycle
//
// Modports:
//   master - the environment (input buffers + link driver)
//   slave  - the arbiter itself
// -----------------------------------------------------------------------------
interface noc_out_port_arbiter_if #(
    parameter int WIDTH_PACKET = 57,
    parameter int NUM_IN       = 4
);
    logic [NUM_IN-1:0]              in_valid;
    logic [NUM_IN*WIDTH_PACKET-1:0] in_data;
    logic [NUM_IN-1:0]              in_ready;
    logic                           out_valid;
    logic [WIDTH_PACKET-1:0]        out_data;
    logic [1:0]                     out_src;
    logic                           out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src
    );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_out_port_arbiter
//
// Round-robin arbiter sharing one router output port among four input-port
// requesters. One winner per cycle is captured into a single output register
// and presented downstream with a valid/ready handshake. The output slot may
// be refilled in the same cycle it drains, so a continuously ready downstream
// sees one packet per cycle.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   bus        noc_out_port_arbiter_if.slave (requester and output handshakes)
//   grant_cnt  per-requester saturating accepted-packet counters, requester i
//              in [i*CNT_W +: CNT_W]  (present only with OUT_ARB_STATS_EN)
//
// Optional feature macro: OUT_ARB_STATS_EN
//   Defined   -> grant_cnt port and the saturating counters exist.
//   Undefined -> no counters; all other behaviour identical.
//
// Parameters:
//   WIDTH_PACKET  packet width in bits
//   NUM_IN        number of requesters, only 4 is supported
//   CNT_W         grant counter width (used only with OUT_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module noc_out_port_arbiter #(
    parameter int WIDTH_PACKET = 57,
    parameter int NUM_IN       = 4,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    noc_out_port_arbiter_if.slave       bus
`ifdef OUT_ARB_STATS_EN
    ,
    output logic [NUM_IN*CNT_W-1:0]     grant_cnt
`endif
);

    // The 2-bit source/last-grant encoding and the rotation arithmetic both
    // assume exactly four requesters.
    if (NUM_IN != 4 || CNT_W < 1) begin : g_bad_params
        $error("noc_out_port_arbiter: NUM_IN must be 4 and CNT_W must be >= 1");
    end

    // -------------------------------------------------------------------------
    // FSM encoding: the output register is either empty or holds a packet.
    // -------------------------------------------------------------------------
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]              state_reg;
    logic [0:0]              state_next;
    logic [WIDTH_PACKET-1:0] out_data_reg;
    logic [1:0]              out_src_reg;
    logic [1:0]              last_grant_reg;

    // -------------------------------------------------------------------------
    // Per-requester packet slices and rotated scan order.
    // scan_idx[k] is the requester examined k-th, starting just after the
    // previous winner; scan_req[k] is its request.
    // -------------------------------------------------------------------------
    logic [WIDTH_PACKET-1:0] in_pkt   [NUM_IN];
    logic [1:0]              scan_idx [NUM_IN];
    logic [NUM_IN-1:0]       scan_req;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_scan
        assign in_pkt[gi]   = bus.in_data[gi*WIDTH_PACKET +: WIDTH_PACKET];
        assign scan_idx[gi] = last_grant_reg + 2'(gi + 1);
        assign scan_req[gi] = bus.in_valid[scan_idx[gi]];
    end

    // -------------------------------------------------------------------------
    // Winner selection: the earliest position in the rotated scan with a
    // request. Iterating from the back lets the lowest position overwrite
    // later ones, so no "found" flag is needed.
    // -------------------------------------------------------------------------
    logic [1:0] win;
    logic       any_req;

    always_comb begin
        win     = scan_idx[0];
        any_req = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (scan_req[k]) begin
                win     = scan_idx[k];
                any_req = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slot availability and grant.
    // The slot is free when empty or when its current packet leaves this
    // cycle. Holding in_ready low during reset keeps a requester from
    // believing a packet was taken while the reset discards it.
    // -------------------------------------------------------------------------
    logic out_valid_int;
    logic avail;
    logic grant;

    assign out_valid_int = (state_reg == ST_FULL);
    assign avail         = !out_valid_int || bus.out_ready;
    assign grant         = any_req && avail && !reset;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
        assign bus.in_ready[gi] = grant && (win == 2'(gi));
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // A grant always lands a packet in the register (refill on drain keeps it
    // FULL); without a grant a draining FULL slot becomes EMPTY, otherwise it
    // holds.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (grant) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (grant) begin
                    state_next = ST_FULL;
                end else if (bus.out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output register.
    // last_grant resets to 3 so requester 0 is first in the scan.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_EMPTY;
            out_data_reg   <= '0;
            out_src_reg    <= 2'd0;
            last_grant_reg <= 2'd3;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                out_data_reg   <= in_pkt[win];
                out_src_reg    <= win;
                last_grant_reg <= win;
            end
        end
    end

    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;

`ifdef OUT_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating per-requester accepted-packet counters.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stats
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (bus.in_valid[gi] && bus.in_ready[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_out_port_arbiter
//
// Directed vector table covering rotation, single-requester streaming,
// back-pressure, priority after a grant and reset while full, followed by a
// randomized run checked against a behavioural model of the round-robin
// output port (and, with OUT_ARB_STATS_EN, a counter saturation sequence).
// -----------------------------------------------------------------------------
module tb_noc_out_port_arbiter;

    localparam int W   = 57;
    localparam int N   = 4;
    localparam int CW  = 4;

    logic clk;
    logic reset;

    noc_out_port_arbiter_if #(.WIDTH_PACKET(W), .NUM_IN(N)) bus ();

`ifdef OUT_ARB_STATS_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    noc_out_port_arbiter #(
        .WIDTH_PACKET(W),
        .NUM_IN(N),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef OUT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed vectors: inputs applied for one cycle, in_ready expected before
    // the edge, registered outputs expected after it.
    // -------------------------------------------------------------------------
    typedef struct {
        logic               rst;
        logic [3:0]         iv;
        logic [3:0][W-1:0]  d;
        logic               ordy;
        logic [3:0]         erdy;
        logic               eov;
        logic [W-1:0]       eod;
        logic [1:0]         esrc;
        logic               chk_od;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] iv,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic ordy, input logic [3:0] erdy, input logic eov,
                                input int eod, input int esrc, input logic chk_od);
        vec_t v;
        v.rst    = rst;
        v.iv     = iv;
        v.d[0]   = W'(d0);
        v.d[1]   = W'(d1);
        v.d[2]   = W'(d2);
        v.d[3]   = W'(d3);
        v.ordy   = ordy;
        v.erdy   = erdy;
        v.eov    = eov;
        v.eod    = W'(eod);
        v.esrc   = 2'(esrc);
        v.chk_od = chk_od;
        vecs.push_back(v);
    endfunction

    // Random-phase model state
    int           m_lg;
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_src;
    bit           pend  [N];
    logic [W-1:0] pdata [N];
    int           m_cnt [N];

    initial begin
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        //   rst iv      d0  d1  d2  d3  ordy erdy    ov od   src chk
        add(1, 4'b0000, 0,  0,  0,  0,  0,   4'b0000, 0, 0,   0,  1);
        // all four sending: strict rotation 0,1,2,3,0,1,2,3
        add(0, 4'b1111, 0,  1,  2,  3,  1,   4'b0001, 1, 0,   0,  1);
        add(0, 4'b1111, 4,  1,  2,  3,  1,   4'b0010, 1, 1,   1,  1);
        add(0, 4'b1111, 4,  5,  2,  3,  1,   4'b0100, 1, 2,   2,  1);
        add(0, 4'b1111, 4,  5,  6,  3,  1,   4'b1000, 1, 3,   3,  1);
        add(0, 4'b1111, 4,  5,  6,  7,  1,   4'b0001, 1, 4,   0,  1);
        add(0, 4'b1110, 0,  5,  6,  7,  1,   4'b0010, 1, 5,   1,  1);
        add(0, 4'b1100, 0,  0,  6,  7,  1,   4'b0100, 1, 6,   2,  1);
        add(0, 4'b1000, 0,  0,  0,  7,  1,   4'b1000, 1, 7,   3,  1);
        add(0, 4'b0000, 0,  0,  0,  0,  1,   4'b0000, 0, 0,   0,  0);
        // only requester 2, back-to-back
        add(0, 4'b0100, 0,  0,  100,0,  1,   4'b0100, 1, 100, 2,  1);
        add(0, 4'b0100, 0,  0,  101,0,  1,   4'b0100, 1, 101, 2,  1);
        add(0, 4'b0100, 0,  0,  102,0,  1,   4'b0100, 1, 102, 2,  1);
        add(0, 4'b0000, 0,  0,  0,  0,  1,   4'b0000, 0, 0,   0,  0);
        // back-pressure: 10 captured, held 5 cycles, then 11
        add(0, 4'b0011, 10, 11, 0,  0,  0,   4'b0001, 1, 10,  0,  1);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0010, 0, 11, 0, 0, 0,  4'b0000, 1, 10,  0,  1);
        add(0, 4'b0010, 0,  11, 0,  0,  1,   4'b0010, 1, 11,  1,  1);
        add(0, 4'b0000, 0,  0,  0,  0,  1,   4'b0000, 0, 0,   0,  0);
        // priority rotation after a grant to 3
        add(0, 4'b1000, 0,  0,  0,  33, 1,   4'b1000, 1, 33,  3,  1);
        add(0, 4'b1001, 40, 0,  0,  34, 1,   4'b0001, 1, 40,  0,  1);
        add(0, 4'b1000, 0,  0,  0,  34, 1,   4'b1000, 1, 34,  3,  1);
        add(0, 4'b0000, 0,  0,  0,  0,  1,   4'b0000, 0, 0,   0,  0);
        // reset while FULL and stalled, then requester 0 wins first
        add(0, 4'b0001, 55, 0,  0,  0,  1,   4'b0001, 1, 55,  0,  1);
        add(0, 4'b0000, 0,  0,  0,  0,  0,   4'b0000, 1, 55,  0,  1);
        add(1, 4'b1111, 60, 61, 62, 63, 0,   4'b0000, 0, 0,   0,  1);
        add(0, 4'b1111, 60, 61, 62, 63, 1,   4'b0001, 1, 60,  0,  1);
        add(0, 4'b1110, 0,  61, 62, 63, 1,   4'b0010, 1, 61,  1,  1);

        @(posedge clk);
        #1;
        foreach (vecs[n]) begin
            reset         = vecs[n].rst;
            bus.in_valid  = vecs[n].iv;
            bus.in_data   = vecs[n].d;
            bus.out_ready = vecs[n].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", n), 64'(bus.in_ready), 64'(vecs[n].erdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", n), 64'(bus.out_valid), 64'(vecs[n].eov));
            if (vecs[n].chk_od) begin
                check($sformatf("vec%0d_out_data", n), 64'(bus.out_data), 64'(vecs[n].eod));
                check($sformatf("vec%0d_out_src", n), 64'(bus.out_src), 64'(vecs[n].esrc));
            end
            $display("vec %0d rst=%b iv=%b ordy=%b -> in_ready=%b out_valid=%b out_data=%0d out_src=%0d",
                     n, vecs[n].rst, vecs[n].iv, vecs[n].ordy, bus.in_ready, bus.out_valid,
                     bus.out_data, bus.out_src);
        end

        // ---------------------------------------------------------------------
        // Randomized run against the behavioural model.
        // ---------------------------------------------------------------------
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_lg  = 3;
        m_ov  = 0;
        m_od  = '0;
        m_src = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            pdata[i] = '0;
            m_cnt[i] = 0;
        end

        for (int r = 0; r < 400; r++) begin
            logic [3:0] exp_rdy;
            int         win;
            bit         ordy;
            logic [63:0] t;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    t        = {$urandom(), $urandom()};
                    pend[i]  = 1;
                    pdata[i] = t[W-1:0];
                end
                bus.in_valid[i]           = pend[i];
                bus.in_data[i*W +: W]     = pdata[i];
            end
            ordy          = ($urandom_range(0, 3) != 0);
            bus.out_ready = ordy;

            // Round-robin: first pending requester after the last winner,
            // granted only if the output slot is free or draining.
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_lg + k) % N;
                if (win < 0 && pend[idx]) win = idx;
            end
            exp_rdy = '0;
            if (win >= 0 && (!m_ov || ordy)) exp_rdy[win] = 1'b1;

            #1;
            check($sformatf("rnd%0d_in_ready", r), 64'(bus.in_ready), 64'(exp_rdy));
            @(posedge clk);

            if (exp_rdy != 0) begin
                m_ov       = 1;
                m_od       = pdata[win];
                m_src      = win;
                m_lg       = win;
                pend[win]  = 0;
                if (m_cnt[win] < (1 << CW) - 1) m_cnt[win]++;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end

            #1;
            check($sformatf("rnd%0d_out_valid", r), 64'(bus.out_valid), 64'(m_ov));
            if (m_ov) begin
                check($sformatf("rnd%0d_out_data", r), 64'(bus.out_data), 64'(m_od));
                check($sformatf("rnd%0d_out_src", r), 64'(bus.out_src), 64'(m_src));
            end
`ifdef OUT_ARB_STATS_EN
            for (int i = 0; i < N; i++)
                check($sformatf("rnd%0d_grant_cnt%0d", r, i), 64'(grant_cnt[i*CW +: CW]), 64'(m_cnt[i]));
`endif
            if (exp_rdy != 0)
                $display("rnd %0d grant src=%0d data=%0h out_ready=%b", r, win, pdata[win], ordy);
        end

`ifdef OUT_ARB_STATS_EN
        // ---------------------------------------------------------------------
        // 20 grants to requester 1 saturate its 4-bit counter at 15.
        // ---------------------------------------------------------------------
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("stats_cleared", 64'(grant_cnt), 64'(0));
        for (int g = 0; g < 20; g++) begin
            bus.in_valid          = 4'b0010;
            bus.in_data[1*W +: W] = W'(200 + g);
            @(posedge clk);
            #1;
            $display("stats grant %0d grant_cnt1=%0d", g, grant_cnt[1*CW +: CW]);
        end
        bus.in_valid = '0;
        check("stats_cnt1_saturated", 64'(grant_cnt[1*CW +: CW]), 64'(15));
        check("stats_cnt0", 64'(grant_cnt[0*CW +: CW]), 64'(0));
        check("stats_cnt2", 64'(grant_cnt[2*CW +: CW]), 64'(0));
        check("stats_cnt3", 64'(grant_cnt[3*CW +: CW]), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
